decode_stage_controller: RTL and testbench

//  Sequencer for the ID stage of the RV32IM pipeline: owns the IF/ID register, decodes the opcode into the 3-bit

---
 rtl/decode_stage_if.sv | 66 ++++++
 rtl/decode_stage_controller.sv | 166 ++++++++++++++++
 tb/tb_decode_stage_controller.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// -----------------------------------------------------------------------------
// decode_stage_if
// Bundles the fetch-side inputs, the EX-side control inputs and the ID-stage
// outputs of the decode stage controller.
//
//   instr_in_i      fetch -> ID   instruction from fetch
//   pc_in_i         fetch -> ID   PC of instr_in_i
//   if_valid_i      fetch -> ID   instr_in_i is a real instruction
//   branch_taken_i  EX    -> ID   taken branch/jump resolved this cycle (flush)
//   ex_busy_i       EX    -> ID   EX cannot accept an instruction this cycle
//   instruction_o   ID    -> out  registered ID instruction
//   pc_out_o        ID    -> out  registered PC of instruction_o
//   immediate_sel_o ID    -> out  registered immediate select
//   id_valid_o      ID    -> out  ID register holds a live instruction
//   pc_stall_o      ID    -> out  hold PC and fetch output (combinational)
//   issue_valid_o   ID    -> out  ID/EX loads a live instruction this cycle
//   stall_count_o   ID    -> out  saturating count of pc_stall_o cycles
//
// master: the environment (fetch/EX side). slave: the controller.
// -----------------------------------------------------------------------------
interface decode_stage_if #(
    parameter int CNT_WIDTH = 16
);
    logic [31:0]          instr_in_i;
    logic [31:0]          pc_in_i;
    logic                 if_valid_i;
    logic                 branch_taken_i;
    logic                 ex_busy_i;
    logic [31:0]          instruction_o;
    logic [31:0]          pc_out_o;
    logic [2:0]           immediate_sel_o;
    logic                 id_valid_o;
    logic                 pc_stall_o;
    logic                 issue_valid_o;
    logic [CNT_WIDTH-1:0] stall_count_o;

    modport master (
        output instr_in_i,
        output pc_in_i,
        output if_valid_i,
        output branch_taken_i,
        output ex_busy_i,
        input  instruction_o,
        input  pc_out_o,
        input  immediate_sel_o,
        input  id_valid_o,
        input  pc_stall_o,
        input  issue_valid_o,
        input  stall_count_o
    );

    modport slave (
        input  instr_in_i,
        input  pc_in_i,
        input  if_valid_i,
        input  branch_taken_i,
        input  ex_busy_i,
        output instruction_o,
        output pc_out_o,
        output immediate_sel_o,
        output id_valid_o,
        output pc_stall_o,
        output issue_valid_o,
        output stall_count_o
    );
endinterface

// File: rtl/decode_stage_controller.sv
// -----------------------------------------------------------------------------
// decode_stage_controller
// Sequencer for the ID stage of an RV32IM pipeline. Owns the IF/ID register,
// decodes the opcode into the immediate-unit select, and stalls, bubbles or
// flushes the stage for load-use hazards, EX back-pressure and taken branches.
//
// Ports:
//   clk_i   clock, all state updates on the rising edge
//   rst_i   synchronous active-high reset
//   bus     decode_stage_if.slave (fetch inputs, EX control, ID outputs)
//
// State | meaning
// ------+---------------------------------------------------------------
// RUN   | normal advance
// LU    | cycle after a load-use bubble; hazard detection is masked so a
//       | single load can never produce more than one bubble
// HOLD  | EX back-pressure, ID register and EX tracking held
// -----------------------------------------------------------------------------
module decode_stage_controller #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_WIDTH = 16
) (
    input logic           clk_i,
    input logic           rst_i,
    decode_stage_if.slave bus
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] SEL_U    = 3'b000;
    localparam logic [2:0] SEL_J    = 3'b001;
    localparam logic [2:0] SEL_I    = 3'b010;
    localparam logic [2:0] SEL_B    = 3'b011;
    localparam logic [2:0] SEL_S    = 3'b100;
    localparam logic [2:0] SEL_NONE = 3'b111;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LU   = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    function automatic logic [2:0] imm_sel_f(input logic [6:0] opcode);
        logic [2:0] sel;
        case (opcode)
            OP_LUI, OP_AUIPC:                     sel = SEL_U;
            OP_JAL:                               sel = SEL_J;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:  sel = SEL_I;
            OP_BRANCH:                            sel = SEL_B;
            OP_STORE:                             sel = SEL_S;
            default:                              sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    state_e               state_q;
    logic [31:0]          instr_q;
    logic [31:0]          pc_q;
    logic [2:0]           imm_sel_q;
    logic [2:0]           imm_sel_d;
    logic                 id_valid_q;
    logic                 ex_is_load_q;
    logic [4:0]           ex_rd_q;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_d;

    logic [6:0] id_opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       lu_hazard;
    logic       active;
    logic       flush;
    logic       back_pressure;
    logic       bubble;
    logic       pc_stall;
    logic       issue_valid;

    assign imm_sel_d = imm_sel_f(bus.instr_in_i[6:0]);

    assign id_opcode = instr_q[6:0];
    assign id_rs1    = instr_q[19:15];
    assign id_rs2    = instr_q[24:20];

    assign uses_rs1 = !((id_opcode == OP_LUI) || (id_opcode == OP_AUIPC) ||
                        (id_opcode == OP_JAL));
    assign uses_rs2 = (id_opcode == OP_REG) || (id_opcode == OP_STORE) ||
                      (id_opcode == OP_BRANCH);

    // x0 as a load destination never creates a dependency.
    assign lu_hazard = id_valid_q && ex_is_load_q && (ex_rd_q != 5'd0) &&
                       (state_q != ST_LU) &&
                       ((uses_rs1 && (id_rs1 == ex_rd_q)) ||
                        (uses_rs2 && (id_rs2 == ex_rd_q)));

    // Priority: reset > flush > back-pressure > load-use bubble > advance.
    assign active        = !rst_i;
    assign flush         = active && bus.branch_taken_i;
    assign back_pressure = active && !bus.branch_taken_i && bus.ex_busy_i;
    assign bubble        = active && !bus.branch_taken_i && !bus.ex_busy_i && lu_hazard;
    assign pc_stall      = back_pressure || bubble;
    assign issue_valid   = active && !flush && !back_pressure && !bubble && id_valid_q;

    assign stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : (stall_cnt_q + CNT_ONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_RUN;
            instr_q      <= NOP_INSTR;
            pc_q         <= PC_RESET;
            imm_sel_q    <= SEL_NONE;
            id_valid_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_rd_q      <= 5'd0;
            stall_cnt_q  <= '0;
        end else begin
            if (pc_stall) begin
                stall_cnt_q <= stall_cnt_d;
            end

            if (flush) begin
                state_q      <= ST_RUN;
                instr_q      <= NOP_INSTR;
                imm_sel_q    <= SEL_NONE;
                id_valid_q   <= 1'b0;
                ex_is_load_q <= 1'b0;
            end else if (back_pressure) begin
                state_q <= ST_HOLD;
            end else if (bubble) begin
                // The bubble enters EX, so EX no longer holds the load.
                state_q      <= ST_LU;
                ex_is_load_q <= 1'b0;
            end else begin
                state_q      <= ST_RUN;
                instr_q      <= bus.instr_in_i;
                pc_q         <= bus.pc_in_i;
                imm_sel_q    <= imm_sel_d;
                id_valid_q   <= bus.if_valid_i;
                ex_is_load_q <= id_valid_q && (id_opcode == OP_LOAD);
                ex_rd_q      <= instr_q[11:7];
            end
        end
    end

    assign bus.instruction_o   = instr_q;
    assign bus.pc_out_o        = pc_q;
    assign bus.immediate_sel_o = imm_sel_q;
    assign bus.id_valid_o      = id_valid_q;
    assign bus.pc_stall_o      = pc_stall;
    assign bus.issue_valid_o   = issue_valid;
    assign bus.stall_count_o   = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage_controller.sv
// -----------------------------------------------------------------------------
// tb_decode_stage_controller
// Directed bench for decode_stage_controller. Expected issues are queued as
// instructions are fed; a negedge monitor pops and compares on every issue.
// A second instance with a 4-bit counter shares the stimulus.
// -----------------------------------------------------------------------------
module tb_decode_stage_controller;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] I_LUI   = 32'h1234_50B7;
    localparam logic [31:0] I_JAL   = 32'h0000_006F;
    localparam logic [31:0] I_ADDI  = 32'hFFC1_0113;
    localparam logic [31:0] I_BEQ   = 32'h0020_8463;
    localparam logic [31:0] I_SW    = 32'h0011_2023;
    localparam logic [31:0] I_ADD   = 32'h0020_81B3;
    localparam logic [31:0] I_LW5   = 32'h0000_A283;   // lw  x5,0(x1)
    localparam logic [31:0] I_ADD6  = 32'h0072_8333;   // add x6,x5,x7
    localparam logic [31:0] I_LW0   = 32'h0000_A003;   // lw  x0,0(x1)
    localparam logic [31:0] I_ADD60 = 32'h0070_0333;   // add x6,x0,x7

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  sel;
    } issue_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_if #(.CNT_WIDTH(16)) ifc ();
    decode_stage_if #(.CNT_WIDTH(4))  sif ();

    decode_stage_controller #(
        .PC_RESET (32'h0000_0000),
        .NOP_INSTR(NOP),
        .CNT_WIDTH(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (ifc)
    );

    decode_stage_controller #(
        .PC_RESET (32'h0000_0000),
        .NOP_INSTR(NOP),
        .CNT_WIDTH(4)
    ) dut_sat (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (sif)
    );

    assign sif.instr_in_i     = ifc.instr_in_i;
    assign sif.pc_in_i        = ifc.pc_in_i;
    assign sif.if_valid_i     = ifc.if_valid_i;
    assign sif.branch_taken_i = ifc.branch_taken_i;
    assign sif.ex_busy_i      = ifc.ex_busy_i;

    issue_t exp_q[$];
    issue_t mon_e;
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic vld, input logic br, input logic busy);
        ifc.instr_in_i     = instr;
        ifc.pc_in_i        = pc;
        ifc.if_valid_i     = vld;
        ifc.branch_taken_i = br;
        ifc.ex_busy_i      = busy;
    endtask

    task automatic idle();
        drive(NOP, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_issue(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [2:0] sel);
        issue_t e;
        e.instr = instr;
        e.pc    = pc;
        e.sel   = sel;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr"},  ifc.instruction_o,   NOP);
        check({tag, "_pc"},     ifc.pc_out_o,        32'h0);
        check({tag, "_sel"},    {29'd0, ifc.immediate_sel_o}, 32'd7);
        check({tag, "_idv"},    {31'd0, ifc.id_valid_o},      32'd0);
        check({tag, "_cnt"},    {16'd0, ifc.stall_count_o},   32'd0);
        check({tag, "_satcnt"}, {28'd0, sif.stall_count_o},   32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        idle();
        @(negedge clk);
        check({tag, "_rst_stall"}, {31'd0, ifc.pc_stall_o},    32'd0);
        check({tag, "_rst_issue"}, {31'd0, ifc.issue_valid_o}, 32'd0);
        tick();
        tick();
        check_reset_outputs(tag);
        rst = 1'b0;
    endtask

    // Issue monitor: every ISSUE_VALID must match the oldest queued instruction.
    always @(negedge clk) begin
        if (ifc.issue_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL issue_unexpected: got %h expected no issue at %0t",
                         ifc.instruction_o, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("issue_instr", ifc.instruction_o, mon_e.instr);
                check("issue_pc",    ifc.pc_out_o,      mon_e.pc);
                check("issue_sel",   {29'd0, ifc.immediate_sel_o}, {29'd0, mon_e.sel});
            end
        end
    end

    initial begin
        // T1 reset
        do_reset("t1");

        // T2 decode of each format, one issue per instruction
        drive(I_LUI, 32'h100, 1'b1, 1'b0, 1'b0); expect_issue(I_LUI, 32'h100, 3'b000); tick();
        check("t2_sel_lui", {29'd0, ifc.immediate_sel_o}, 32'd0);
        check("t2_idv",     {31'd0, ifc.id_valid_o},      32'd1);
        drive(I_JAL, 32'h104, 1'b1, 1'b0, 1'b0); expect_issue(I_JAL, 32'h104, 3'b001); tick();
        check("t2_sel_jal", {29'd0, ifc.immediate_sel_o}, 32'd1);
        drive(I_ADDI, 32'h108, 1'b1, 1'b0, 1'b0); expect_issue(I_ADDI, 32'h108, 3'b010); tick();
        check("t2_sel_addi", {29'd0, ifc.immediate_sel_o}, 32'd2);
        drive(I_BEQ, 32'h10C, 1'b1, 1'b0, 1'b0); expect_issue(I_BEQ, 32'h10C, 3'b011); tick();
        check("t2_sel_beq", {29'd0, ifc.immediate_sel_o}, 32'd3);
        drive(I_SW, 32'h110, 1'b1, 1'b0, 1'b0); expect_issue(I_SW, 32'h110, 3'b100); tick();
        check("t2_sel_sw", {29'd0, ifc.immediate_sel_o}, 32'd4);
        drive(I_ADD, 32'h114, 1'b1, 1'b0, 1'b0); expect_issue(I_ADD, 32'h114, 3'b111); tick();
        check("t2_sel_add", {29'd0, ifc.immediate_sel_o}, 32'd7);
        idle(); tick();
        check("t2_cnt", {16'd0, ifc.stall_count_o}, 32'd0);

        // T3 load-use: one bubble, then the dependent ADD issues
        drive(I_LW5, 32'h200, 1'b1, 1'b0, 1'b0); expect_issue(I_LW5, 32'h200, 3'b010); tick();
        drive(I_ADD6, 32'h204, 1'b1, 1'b0, 1'b0); expect_issue(I_ADD6, 32'h204, 3'b111); tick();
        idle();
        @(negedge clk);
        check("t3_lu_stall", {31'd0, ifc.pc_stall_o},    32'd1);
        check("t3_lu_issue", {31'd0, ifc.issue_valid_o}, 32'd0);
        tick();
        check("t3_lu_cnt",   {16'd0, ifc.stall_count_o}, 32'd1);
        check("t3_lu_hold",  ifc.instruction_o,          I_ADD6);
        @(negedge clk);
        check("t3_after_stall", {31'd0, ifc.pc_stall_o},    32'd0);
        check("t3_after_issue", {31'd0, ifc.issue_valid_o}, 32'd1);
        tick();

        // rd = x0: no stall
        drive(I_LW0, 32'h210, 1'b1, 1'b0, 1'b0); expect_issue(I_LW0, 32'h210, 3'b010); tick();
        drive(I_ADD60, 32'h214, 1'b1, 1'b0, 1'b0); expect_issue(I_ADD60, 32'h214, 3'b111); tick();
        idle();
        @(negedge clk);
        check("t3_x0_stall", {31'd0, ifc.pc_stall_o},    32'd0);
        check("t3_x0_issue", {31'd0, ifc.issue_valid_o}, 32'd1);
        tick();
        check("t3_x0_cnt", {16'd0, ifc.stall_count_o}, 32'd1);

        // dependent instruction in an invalid ID slot: no stall
        drive(I_LW5, 32'h220, 1'b1, 1'b0, 1'b0); expect_issue(I_LW5, 32'h220, 3'b010); tick();
        drive(I_ADD6, 32'h224, 1'b0, 1'b0, 1'b0); tick();
        idle();
        @(negedge clk);
        check("t3_inv_stall", {31'd0, ifc.pc_stall_o}, 32'd0);
        tick();

        // T4 flush of a valid ID instruction; INSTR_IN discarded
        drive(I_ADDI, 32'h300, 1'b1, 1'b0, 1'b0); expect_issue(I_ADDI, 32'h300, 3'b010); tick();
        drive(I_BEQ, 32'h304, 1'b1, 1'b1, 1'b0); void'(exp_q.pop_back());
        @(negedge clk);
        check("t4_fl_issue", {31'd0, ifc.issue_valid_o}, 32'd0);
        check("t4_fl_stall", {31'd0, ifc.pc_stall_o},    32'd0);
        tick();
        check("t4_fl_idv",   {31'd0, ifc.id_valid_o},      32'd0);
        check("t4_fl_instr", ifc.instruction_o,            NOP);
        check("t4_fl_sel",   {29'd0, ifc.immediate_sel_o}, 32'd7);

        // flush together with a load-use hazard: flush wins
        drive(I_LW5, 32'h310, 1'b1, 1'b0, 1'b0); expect_issue(I_LW5, 32'h310, 3'b010); tick();
        drive(I_ADD6, 32'h314, 1'b1, 1'b0, 1'b0); expect_issue(I_ADD6, 32'h314, 3'b111); tick();
        drive(NOP, 32'h0, 1'b0, 1'b1, 1'b0); void'(exp_q.pop_back());
        @(negedge clk);
        check("t4_flhz_stall", {31'd0, ifc.pc_stall_o},    32'd0);
        check("t4_flhz_issue", {31'd0, ifc.issue_valid_o}, 32'd0);
        tick();
        check("t4_flhz_idv", {31'd0, ifc.id_valid_o},    32'd0);
        check("t4_flhz_cnt", {16'd0, ifc.stall_count_o}, 32'd1);
        idle(); tick();

        // T5 back-pressure for 33 cycles
        do_reset("t5");
        drive(I_ADDI, 32'h400, 1'b1, 1'b0, 1'b0); expect_issue(I_ADDI, 32'h400, 3'b010); tick();
        for (int i = 0; i < 33; i++) begin
            drive(I_SW, 32'h404, 1'b1, 1'b0, 1'b1);
            @(negedge clk);
            check("t5_bp_stall", {31'd0, ifc.pc_stall_o}, 32'd1);
            check("t5_bp_instr", ifc.instruction_o,       I_ADDI);
            tick();
        end
        check("t5_cnt",    {16'd0, ifc.stall_count_o}, 32'd33);
        check("t5_satcnt", {28'd0, sif.stall_count_o}, 32'd15);
        drive(I_SW, 32'h404, 1'b1, 1'b0, 1'b0); expect_issue(I_SW, 32'h404, 3'b100);
        @(negedge clk);
        check("t5_resume_issue", {31'd0, ifc.issue_valid_o}, 32'd1);
        check("t5_resume_stall", {31'd0, ifc.pc_stall_o},    32'd0);
        tick();
        idle(); tick();
        check("t5_cnt_after", {16'd0, ifc.stall_count_o}, 32'd33);

        // T6 saturation of the 4-bit counter
        do_reset("t6");
        for (int i = 0; i < 20; i++) begin
            drive(NOP, 32'h0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        check("t6_cnt",    {16'd0, ifc.stall_count_o}, 32'd20);
        check("t6_satcnt", {28'd0, sif.stall_count_o}, 32'd15);

        // reset during a load-use bubble
        drive(I_LW5, 32'h500, 1'b1, 1'b0, 1'b0); expect_issue(I_LW5, 32'h500, 3'b010); tick();
        drive(I_ADD6, 32'h504, 1'b1, 1'b0, 1'b0); expect_issue(I_ADD6, 32'h504, 3'b111); tick();
        rst = 1'b1;
        idle();
        void'(exp_q.pop_back());
        @(negedge clk);
        check("t6_rst_stall", {31'd0, ifc.pc_stall_o},    32'd0);
        check("t6_rst_issue", {31'd0, ifc.issue_valid_o}, 32'd0);
        tick();
        check_reset_outputs("t6_rst");
        rst = 1'b0;
        idle();
        @(negedge clk);
        check("t6_post_stall", {31'd0, ifc.pc_stall_o},    32'd0);
        check("t6_post_issue", {31'd0, ifc.issue_valid_o}, 32'd0);
        tick();
        tick();

        check("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
